// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception/ERET commit controller: CP0 exc_type bit
// positions, raw flag positions, the default exception vector and FSM states.
package exc_commit_ctrl_pkg;

    localparam int EXC_W    = 7;
    localparam int EXC_INT  = 6;
    localparam int EXC_ADEL = 5;
    localparam int EXC_ADES = 4;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BP   = 2;
    localparam int EXC_RI   = 1;
    localparam int EXC_OV   = 0;

    // Bit positions inside the raw ws_exc vector {adel_if, ri, ov, sys, bp, ades}
    localparam int RAW_W       = 6;
    localparam int RAW_ADEL_IF = 5;
    localparam int RAW_RI      = 4;
    localparam int RAW_OV      = 3;
    localparam int RAW_SYS     = 2;
    localparam int RAW_BP      = 1;
    localparam int RAW_ADES    = 0;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    function automatic logic [EXC_W-1:0] excBit(input int idx);
        logic [EXC_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Exception priority encoder: raw flags plus pending interrupt in, one-hot CP0
// exc_type out, along with which address source feeds bad_vaddr.
module exc_commit_ctrl_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic             i_intHappen,
    input  logic [RAW_W-1:0] i_exc,
    input  logic             i_adelLd,
    output logic [EXC_W-1:0] o_excType,
    output logic             o_isAdelIf,
    output logic             o_isDataAddr
);

    // Interrupt wins over everything; fetch address errors beat data address errors.
    always_comb begin
        o_excType    = '0;
        o_isAdelIf   = 1'b0;
        o_isDataAddr = 1'b0;
        if (i_intHappen) begin
            o_excType = excBit(EXC_INT);
        end else if (i_exc[RAW_ADEL_IF]) begin
            o_excType  = excBit(EXC_ADEL);
            o_isAdelIf = 1'b1;
        end else if (i_exc[RAW_RI]) begin
            o_excType = excBit(EXC_RI);
        end else if (i_exc[RAW_OV]) begin
            o_excType = excBit(EXC_OV);
        end else if (i_exc[RAW_SYS]) begin
            o_excType = excBit(EXC_SYS);
        end else if (i_exc[RAW_BP]) begin
            o_excType = excBit(EXC_BP);
        end else if (i_adelLd) begin
            o_excType    = excBit(EXC_ADEL);
            o_isDataAddr = 1'b1;
        end else if (i_exc[RAW_ADES]) begin
            o_excType    = excBit(EXC_ADES);
            o_isDataAddr = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit controller at the writeback boundary: pulses CP0 once per
// trapping instruction, holds flush, then offers a redirect PC to fetch.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ws_valid,
    output logic             ws_ready,
    input  logic [RAW_W-1:0] ws_exc,
    input  logic             ws_adel_ld,
    input  logic             ws_eret,
    input  logic [31:0]      ws_pc,
    input  logic             ws_is_slot,
    input  logic [31:0]      ws_data_vaddr,
    input  logic             int_happen,
    input  logic [31:0]      cp0_epc,
    output logic [EXC_W-1:0] exc_type,
    output logic [31:0]      exc_pc,
    output logic             exc_is_slot,
    output logic [31:0]      exc_bad_vaddr,
    output logic             eret,
    output logic             flush,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_count;
    logic [3:0]       w_nextCount;
    logic [31:0]      r_redirPc;
    logic [31:0]      w_nextRedirPc;

    logic [EXC_W-1:0] w_excType;
    logic             w_isAdelIf;
    logic             w_isDataAddr;
    logic             w_accept;
    logic             w_anyExc;
    logic             w_trigger;

    exc_commit_ctrl_prio_enc u_prioEnc (
        .i_intHappen  (int_happen),
        .i_exc        (ws_exc),
        .i_adelLd     (ws_adel_ld),
        .o_excType    (w_excType),
        .o_isAdelIf   (w_isAdelIf),
        .o_isDataAddr (w_isDataAddr)
    );

    // Accept is gated by resetn so no CP0 pulse can leak out while reset is held.
    assign ws_ready  = (r_state == ST_IDLE);
    assign w_accept  = ws_valid & ws_ready & resetn;
    assign w_anyExc  = int_happen | (|ws_exc) | ws_adel_ld;
    assign w_trigger = w_accept & (w_anyExc | ws_eret);

    assign exc_type      = w_accept ? w_excType : '0;
    assign eret          = w_accept & ws_eret & ~w_anyExc;
    assign exc_pc        = w_trigger ? ws_pc : '0;
    assign exc_is_slot   = w_trigger & ws_is_slot;
    assign exc_bad_vaddr = !w_accept    ? '0 :
                           w_isAdelIf   ? ws_pc :
                           w_isDataAddr ? ws_data_vaddr : '0;

    assign flush          = w_trigger | (r_state != ST_IDLE);
    assign redirect_valid = (r_state == ST_REDIR);
    assign redirect_pc    = redirect_valid ? r_redirPc : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_redirPc <= '0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_nextCount;
            r_redirPc <= w_nextRedirPc;
        end
    end

    // The redirect target is captured on accept; cp0_epc is only meaningful that cycle.
    always_comb begin
        w_nextState   = r_state;
        w_nextCount   = r_count;
        w_nextRedirPc = r_redirPc;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_nextState   = ST_FLUSH;
                    w_nextCount   = FLUSH_LOAD;
                    w_nextRedirPc = w_anyExc ? EXC_VECTOR : cp0_epc;
                end
            end
            ST_FLUSH: begin
                if (r_count == 4'd0) begin
                    w_nextState = ST_REDIR;
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed cases plus randomized
// transactions compared against a priority-table reference model.
module tb_exc_commit_ctrl;

    localparam int          FC     = 2;
    localparam logic [31:0] EXCVEC = 32'hbfc00380;

    logic        clk;
    logic        resetn;
    logic        wsValid;
    logic        wsReady;
    logic [5:0]  wsExc;
    logic        wsAdelLd;
    logic        wsEret;
    logic [31:0] wsPc;
    logic        wsIsSlot;
    logic [31:0] wsDataVaddr;
    logic        intHappen;
    logic [31:0] cp0Epc;
    logic [6:0]  excType;
    logic [31:0] excPc;
    logic        excIsSlot;
    logic [31:0] excBadVaddr;
    logic        eretOut;
    logic        flush;
    logic        redirectValid;
    logic        redirectReady;
    logic [31:0] redirectPc;

    int nCompared   = 0;
    int nMismatched = 0;

    exc_commit_ctrl #(.EXC_VECTOR(EXCVEC), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_valid       (wsValid),
        .ws_ready       (wsReady),
        .ws_exc         (wsExc),
        .ws_adel_ld     (wsAdelLd),
        .ws_eret        (wsEret),
        .ws_pc          (wsPc),
        .ws_is_slot     (wsIsSlot),
        .ws_data_vaddr  (wsDataVaddr),
        .int_happen     (intHappen),
        .cp0_epc        (cp0Epc),
        .exc_type       (excType),
        .exc_pc         (excPc),
        .exc_is_slot    (excIsSlot),
        .exc_bad_vaddr  (excBadVaddr),
        .eret           (eretOut),
        .flush          (flush),
        .redirect_valid (redirectValid),
        .redirect_ready (redirectReady),
        .redirect_pc    (redirectPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Priority table: first true condition, in order, selects the CP0 bit and bad_vaddr source.
    task automatic model(input logic intH, input logic [5:0] f, input logic adelLd,
                         output logic [6:0] et, output int src);
        logic cond [8];
        int   dst  [8];
        int   srcs [8];
        cond = '{intH, f[5], f[4], f[3], f[2], f[1], adelLd, f[0]};
        dst  = '{6, 5, 1, 0, 3, 2, 5, 4};
        srcs = '{0, 1, 0, 0, 0, 0, 2, 2};
        et   = '0;
        src  = 0;
        for (int i = 0; i < 8; i++) begin
            if (cond[i]) begin
                et[dst[i]] = 1'b1;
                src        = srcs[i];
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic intH, input logic [5:0] f, input logic adelLd,
                                 input logic er, input logic [31:0] pc, input logic slot,
                                 input logic [31:0] vaddr, input logic [31:0] epc, input int stall);
        logic [6:0]  et;
        int          src;
        logic        trig;
        logic [31:0] target;
        logic [31:0] expBad;
        model(intH, f, adelLd, et, src);
        trig   = (et != 0) || er;
        target = (et != 0) ? EXCVEC : epc;
        expBad = (src == 1) ? pc : (src == 2) ? vaddr : 32'h0;

        @(posedge clk); #1;
        wsValid = 1'b1; intHappen = intH; wsExc = f; wsAdelLd = adelLd; wsEret = er;
        wsPc = pc; wsIsSlot = slot; wsDataVaddr = vaddr; cp0Epc = epc;
        @(negedge clk);
        checkOutput("acc_ready",   32'(wsReady), 32'h1);
        checkOutput("acc_exctype", 32'(excType), 32'(et));
        checkOutput("acc_eret",    32'(eretOut), 32'((et == 0) && er));
        checkOutput("acc_flush",   32'(flush), 32'(trig));
        if (!trig) begin
            @(posedge clk); #1;
            wsValid = 1'b0;
            @(negedge clk);
            checkOutput("normal_redir", 32'(redirectValid), 32'h0);
            return;
        end
        checkOutput("acc_pc",    excPc, pc);
        checkOutput("acc_slot",  32'(excIsSlot), 32'(slot));
        checkOutput("acc_vaddr", excBadVaddr, expBad);

        // Busy: keep offering junk instructions that must be ignored.
        @(posedge clk); #1;
        wsExc = 6'($urandom); intHappen = 1'($urandom); wsEret = 1'($urandom); cp0Epc = $urandom;
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            checkOutput("fl_flush", 32'(flush), 32'h1);
            checkOutput("fl_ready", 32'(wsReady), 32'h0);
            checkOutput("fl_redir", 32'(redirectValid), 32'h0);
            checkOutput("fl_pulse", 32'({excType, eretOut}), 32'h0);
            @(posedge clk); #1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("rd_valid", 32'(redirectValid), 32'h1);
            checkOutput("rd_pc",    redirectPc, target);
            checkOutput("rd_flush", 32'(flush), 32'h1);
            checkOutput("rd_ready", 32'(wsReady), 32'h0);
            @(posedge clk); #1;
        end
        redirectReady = 1'b1;
        @(negedge clk);
        checkOutput("hs_valid", 32'(redirectValid), 32'h1);
        checkOutput("hs_pc",    redirectPc, target);
        checkOutput("hs_ready", 32'(wsReady), 32'h0);
        @(posedge clk); #1;
        redirectReady = 1'b0;
        wsValid = 1'b0;
        @(negedge clk);
        checkOutput("post_ready", 32'(wsReady), 32'h1);
        checkOutput("post_flush", 32'(flush), 32'h0);
        checkOutput("post_redir", 32'(redirectValid), 32'h0);
    endtask

    initial begin
        resetn = 1'b0; wsValid = 1'b0; wsExc = '0; wsAdelLd = 1'b0; wsEret = 1'b0;
        wsPc = '0; wsIsSlot = 1'b0; wsDataVaddr = '0; intHappen = 1'b0; cp0Epc = '0;
        redirectReady = 1'b0;
        #12;
        checkOutput("rst_ready", 32'(wsReady), 32'h1);
        checkOutput("rst_flush", 32'(flush), 32'h0);
        checkOutput("rst_redir", 32'(redirectValid), 32'h0);
        checkOutput("rst_exc",   32'(excType), 32'h0);
        resetn = 1'b1;

        applyStimulus(1'b0, 6'b000000, 1'b0, 1'b0, 32'h0000_0800, 1'b0, 32'h0, 32'h0, 0);
        applyStimulus(1'b0, 6'b011000, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 32'h0, 32'h0, 0);
        applyStimulus(1'b0, 6'b100000, 1'b0, 1'b0, 32'h0000_1003, 1'b0, 32'h0, 32'h0, 1);
        applyStimulus(1'b0, 6'b000000, 1'b1, 1'b0, 32'h0000_1010, 1'b0, 32'h2001, 32'h0, 0);
        applyStimulus(1'b0, 6'b000001, 1'b0, 1'b0, 32'h0000_1020, 1'b0, 32'h3002, 32'h0, 0);
        applyStimulus(1'b0, 6'b000000, 1'b0, 1'b1, 32'h0000_1030, 1'b0, 32'h0, 32'h400, 0);
        applyStimulus(1'b1, 6'b000000, 1'b0, 1'b1, 32'h0000_1040, 1'b0, 32'h0, 32'h400, 0);
        applyStimulus(1'b0, 6'b000100, 1'b0, 1'b0, 32'h0000_1050, 1'b0, 32'h0, 32'h0, 5);

        // Reset asserted during FLUSH must clear everything immediately.
        @(posedge clk); #1;
        wsValid = 1'b1; wsExc = 6'b010000; wsPc = 32'h1060;
        @(negedge clk);
        checkOutput("rf_acc_flush", 32'(flush), 32'h1);
        @(posedge clk); #1;
        wsValid = 1'b0; wsExc = '0;
        #2 resetn = 1'b0;
        #1;
        checkOutput("rf_flush", 32'(flush), 32'h0);
        checkOutput("rf_redir", 32'(redirectValid), 32'h0);
        checkOutput("rf_pulse", 32'({excType, eretOut}), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rf_ready", 32'(wsReady), 32'h1);
        checkOutput("rf_idle",  32'(flush), 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] f;
            f = 6'($urandom) & 6'($urandom) & 6'($urandom);
            applyStimulus(($urandom_range(0, 4) == 0), f, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0), $urandom, 1'($urandom), $urandom,
                          $urandom, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
